// File: rtl/aes_key_expander_if.sv
// Key-expansion register-file bus: one always-on write port and two combinational read ports.
interface aes_key_expander_if #(
  parameter int ADDR_W = 6,
  parameter int WORD_W = 32
);
  logic [ADDR_W-1:0] Addr_Wr;
  logic [WORD_W-1:0] Wr_Data;
  logic [ADDR_W-1:0] Addr_A;
  logic [ADDR_W-1:0] Addr_B;
  logic [WORD_W-1:0] Rd_A;
  logic [WORD_W-1:0] Rd_B;

  modport master (output Addr_Wr, Wr_Data, Addr_A, Addr_B, input Rd_A, Rd_B);
  modport slave  (input Addr_Wr, Wr_Data, Addr_A, Addr_B, output Rd_A, Rd_B);
endinterface

// File: rtl/aes_key_expander.sv
// AES-128/192/256 key-schedule sequencer: loads the Nk key words into the register file,
// then derives one expanded word per clock from w[i-1] and w[i-Nk] read back from the file.

module aes_sbox (
  input  logic [7:0] x,
  output logic [7:0] y
);
  function automatic logic [7:0] xtime(input logic [7:0] a);
    if (a[7]) return {a[6:0], 1'b0} ^ 8'h1b;
    else      return {a[6:0], 1'b0};
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] t;
    p = 8'h00;
    t = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p = p ^ t;
      else      p = p;
      t = xtime(t);
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254 (square-and-multiply chain); 0 maps to 0.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] r;
    r = a;
    for (int k = 0; k < 6; k++) begin
      r = gf_mul(r, r);
      r = gf_mul(r, a);
    end
    return gf_mul(r, r);
  endfunction

  logic [7:0] b;

  // Inverse followed by the AES affine transform.
  always_comb begin
    b = gf_inv(x);
    y = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  end
endmodule

module aes_key_expander #(
  parameter int ADDR_W = 6,
  parameter int WORD_W = 32
) (
  input  logic               Clk,
  input  logic               Rst,
  input  logic               Start,
  input  logic [1:0]         Key_Len,
  input  logic [255:0]       Key_In,
  aes_key_expander_if.master rf,
  output logic [3:0]         Nr,
  output logic               Busy,
  output logic               Done
);
  typedef enum logic [1:0] {IDLE, LOAD, EXPAND, DONE} state_t;

  state_t            state;
  state_t            state_next;
  logic [255:0]      key;
  logic [3:0]        nk;
  logic [ADDR_W-1:0] total;
  logic [ADDR_W-1:0] idx;
  logic [2:0]        phase;
  logic [7:0]        rcon;
  logic [2:0]        sh;
  logic [WORD_W-1:0] load_word;
  logic [WORD_W-1:0] sub_in;
  logic [WORD_W-1:0] sub_out;
  logic [WORD_W-1:0] temp;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    if (a[7]) return {a[6:0], 1'b0} ^ 8'h1b;
    else      return {a[6:0], 1'b0};
  endfunction

  for (genvar g = 0; g < 4; g++) begin : g_sbox
    aes_sbox u_sbox (.x(sub_in[8*g +: 8]), .y(sub_out[8*g +: 8]));
  end

  // State, counters and captured key; phase tracks i mod Nk without a divider.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state <= IDLE;
      key   <= 256'h0;
      nk    <= 4'd4;
      total <= '0;
      idx   <= '0;
      phase <= 3'd0;
      rcon  <= 8'h01;
      Nr    <= 4'd0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (Start) begin
            key   <= Key_In;
            idx   <= '0;
            phase <= 3'd0;
            rcon  <= 8'h01;
            case (Key_Len)
              2'd1:    begin nk <= 4'd6; Nr <= 4'd12; total <= ADDR_W'(52); end
              2'd2:    begin nk <= 4'd8; Nr <= 4'd14; total <= ADDR_W'(60); end
              default: begin nk <= 4'd4; Nr <= 4'd10; total <= ADDR_W'(44); end
            endcase
          end
        end
        LOAD, EXPAND: begin
          idx   <= idx + ADDR_W'(1);
          phase <= (phase == 3'(nk - 4'd1)) ? 3'd0 : phase + 3'd1;
          if (state == EXPAND && phase == 3'd0) rcon <= xtime(rcon);
        end
        default: ;
      endcase
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (Start) state_next = LOAD; else state_next = IDLE;
      LOAD:    if (idx == ADDR_W'(nk - 4'd1)) state_next = EXPAND; else state_next = LOAD;
      EXPAND:  if (idx == total - ADDR_W'(1)) state_next = DONE; else state_next = EXPAND;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Key-word select for LOAD and the schedule's temp word for EXPAND.
  always_comb begin
    sh        = nk[2:0] - 3'd1 - idx[2:0];
    load_word = WORD_W'(key >> {sh, 5'd0});
    if (phase == 3'd0) sub_in = {rf.Rd_A[23:0], rf.Rd_A[31:24]};
    else               sub_in = rf.Rd_A;
    if (phase == 3'd0)                    temp = sub_out ^ {rcon, 24'h000000};
    else if (nk == 4'd8 && phase == 3'd4) temp = sub_out;
    else                                  temp = rf.Rd_A;
  end

  // File bus; everything parks at zero outside LOAD/EXPAND because the file always writes.
  always_comb begin
    rf.Addr_Wr = '0;
    rf.Wr_Data = '0;
    rf.Addr_A  = '0;
    rf.Addr_B  = '0;
    case (state)
      LOAD: begin
        rf.Addr_Wr = idx + ADDR_W'(1);
        rf.Wr_Data = load_word;
      end
      EXPAND: begin
        rf.Addr_A  = idx;
        rf.Addr_B  = idx - ADDR_W'(nk) + ADDR_W'(1);
        rf.Addr_Wr = idx + ADDR_W'(1);
        rf.Wr_Data = rf.Rd_B ^ temp;
      end
      default: ;
    endcase
  end

  assign Busy = (state == LOAD) || (state == EXPAND);
  assign Done = (state == DONE);
endmodule
